// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared port indices, read type codes, FSM encoding and write-buffer layout
package mem_arb_pkg;
  localparam int ICACHE = 0;
  localparam int DCACHE = 1;
  localparam int UNCACHE = 2;
  localparam logic [2:0] RD_LINE = 3'b100;
  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_RD_REQ = 3'b010;
  localparam logic [2:0] S_RD_RESP = 3'b100;
  typedef struct packed {
    logic [2:0] kind;
    logic [31:0] addr;
    logic [3:0] wstrb;
    logic [127:0] data;
  } wr_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting the search at ptr
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [$clog2(N)-1:0] idx,
  output logic any
);
  localparam int PW = $clog2(N);
  logic [PW-1:0] j;
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      j = PW'((int'(ptr) + k) % N);
      if (req[j] && !any) begin
        grant[j] = 1'b1;
        idx = j;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin sharing of the bridge read port plus a single-entry write buffer;
// reads hitting the buffered write's line are held until the bridge reports that write done.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int LINE_LSB = 4
) (
  input  logic aclk,
  input  logic areset,
  input  logic [NREQ-1:0] rq_rd_req,
  input  logic [3*NREQ-1:0] rq_rd_type,
  input  logic [32*NREQ-1:0] rq_rd_addr,
  output logic [NREQ-1:0] rq_rd_rdy,
  output logic [NREQ-1:0] rq_ret_valid,
  output logic [NREQ-1:0] rq_ret_last,
  output logic [31:0] rq_ret_data,
  input  logic wr_req,
  input  logic [2:0] wr_type,
  input  logic [31:0] wr_addr,
  input  logic [3:0] wr_wstrb,
  input  logic [127:0] wr_data,
  output logic wr_rdy,
  output logic mem_rd_req,
  output logic [2:0] mem_rd_type,
  output logic [31:0] mem_rd_addr,
  input  logic mem_rd_rdy,
  input  logic mem_ret_valid,
  input  logic mem_ret_last,
  input  logic [31:0] mem_ret_data,
  output logic mem_wr_req,
  output logic [2:0] mem_wr_type,
  output logic [31:0] mem_wr_addr,
  output logic [3:0] mem_wr_wstrb,
  output logic [127:0] mem_wr_data,
  input  logic mem_wr_rdy,
  input  logic mem_wr_done
);
  localparam int PW = $clog2(NREQ);
  logic [2:0] state;
  logic [PW-1:0] rr_ptr, owner, gnt_idx;
  logic [NREQ-1:0] own_oh, gnt, hazard, eligible;
  logic gnt_any;
  logic [31:0] rd_addr;
  logic [2:0] rd_type;
  logic [31:0] req_addr [NREQ];
  logic [2:0] req_type [NREQ];
  wr_req_t wbuf;
  logic wbuf_valid, issued;
  for (genvar i = 0; i < NREQ; i++) begin : g_port
    assign req_addr[i] = rq_rd_addr[32*i +: 32];
    assign req_type[i] = rq_rd_type[3*i +: 3];
    assign hazard[i] = wbuf_valid && req_addr[i][31:LINE_LSB] == wbuf.addr[31:LINE_LSB];
  end
  assign eligible = rq_rd_req & ~hazard;
  rr_arbiter #(.N(NREQ)) u_rr (
    .req(eligible),
    .ptr(rr_ptr),
    .grant(gnt),
    .idx(gnt_idx),
    .any(gnt_any)
  );
  // hazard is evaluated only at grant; a latched read proceeds regardless
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= S_IDLE;
      rr_ptr <= '0;
      owner <= '0;
      own_oh <= '0;
      rd_addr <= '0;
      rd_type <= '0;
    end else if (state == S_IDLE) begin
      if (gnt_any) begin
        owner <= gnt_idx;
        own_oh <= gnt;
        rd_addr <= req_addr[gnt_idx];
        rd_type <= req_type[gnt_idx];
        state <= S_RD_REQ;
      end
    end else if (state == S_RD_REQ) begin
      if (mem_rd_rdy) state <= S_RD_RESP;
    end else if (mem_ret_valid && mem_ret_last) begin
      rr_ptr <= owner == PW'(NREQ - 1) ? '0 : owner + 1'b1;
      state <= S_IDLE;
    end
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wbuf <= '0;
      wbuf_valid <= 1'b0;
      issued <= 1'b0;
    end else if (wr_req && wr_rdy) begin
      wbuf <= {wr_type, wr_addr, wr_wstrb, wr_data};
      wbuf_valid <= 1'b1;
      issued <= 1'b0;
    end else begin
      if (mem_wr_req && mem_wr_rdy) issued <= 1'b1;
      if (mem_wr_done && issued) wbuf_valid <= 1'b0;
    end
  end
  assign rq_rd_rdy = state == S_RD_REQ && mem_rd_rdy ? own_oh : '0;
  assign rq_ret_valid = state == S_RD_RESP && mem_ret_valid ? own_oh : '0;
  assign rq_ret_last = state == S_RD_RESP && mem_ret_last ? own_oh : '0;
  assign rq_ret_data = state == S_RD_RESP ? mem_ret_data : '0;
  assign mem_rd_req = state == S_RD_REQ;
  assign mem_rd_type = rd_type;
  assign mem_rd_addr = rd_addr;
  assign wr_rdy = ~wbuf_valid;
  assign mem_wr_req = wbuf_valid & ~issued;
  assign mem_wr_type = wbuf.kind;
  assign mem_wr_addr = wbuf.addr;
  assign mem_wr_wstrb = wbuf.wstrb;
  assign mem_wr_data = wbuf.data;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed scenarios for read arbitration, beat routing, RAW hold, write buffer and async reset
module tb_mem_req_arbiter;
  import mem_arb_pkg::*;
  localparam int NREQ = 3;
  logic aclk = 1'b0, areset = 1'b1;
  logic [NREQ-1:0] rq_rd_req = '0;
  logic [3*NREQ-1:0] rq_rd_type = '0;
  logic [32*NREQ-1:0] rq_rd_addr = '0;
  logic [NREQ-1:0] rq_rd_rdy, rq_ret_valid, rq_ret_last;
  logic [31:0] rq_ret_data;
  logic wr_req = 1'b0;
  logic [2:0] wr_type = '0;
  logic [31:0] wr_addr = '0;
  logic [3:0] wr_wstrb = '0;
  logic [127:0] wr_data = '0;
  logic wr_rdy;
  logic mem_rd_req;
  logic [2:0] mem_rd_type;
  logic [31:0] mem_rd_addr;
  logic mem_rd_rdy = 1'b0, mem_ret_valid = 1'b0, mem_ret_last = 1'b0;
  logic [31:0] mem_ret_data = '0;
  logic mem_wr_req;
  logic [2:0] mem_wr_type;
  logic [31:0] mem_wr_addr;
  logic [3:0] mem_wr_wstrb;
  logic [127:0] mem_wr_data;
  logic mem_wr_rdy = 1'b0, mem_wr_done = 1'b0;
  int passed = 0, total = 0;
  int wr_pulses = 0;
  logic tb_issued = 1'b0;
  logic [NREQ-1:0] vm [4];
  logic [NREQ-1:0] lm [4];
  logic [31:0] dm [4];
  logic idle_req;

  always #5 aclk = ~aclk;

  mem_req_arbiter #(.NREQ(NREQ), .LINE_LSB(4)) dut (
    .aclk(aclk), .areset(areset),
    .rq_rd_req(rq_rd_req), .rq_rd_type(rq_rd_type), .rq_rd_addr(rq_rd_addr),
    .rq_rd_rdy(rq_rd_rdy), .rq_ret_valid(rq_ret_valid), .rq_ret_last(rq_ret_last),
    .rq_ret_data(rq_ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .mem_rd_req(mem_rd_req), .mem_rd_type(mem_rd_type), .mem_rd_addr(mem_rd_addr),
    .mem_rd_rdy(mem_rd_rdy), .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last),
    .mem_ret_data(mem_ret_data),
    .mem_wr_req(mem_wr_req), .mem_wr_type(mem_wr_type), .mem_wr_addr(mem_wr_addr),
    .mem_wr_wstrb(mem_wr_wstrb), .mem_wr_data(mem_wr_data),
    .mem_wr_rdy(mem_wr_rdy), .mem_wr_done(mem_wr_done)
  );

  always @(posedge aclk) begin
    if (mem_wr_req) wr_pulses <= wr_pulses + 1;
    if (areset) tb_issued <= 1'b0;
    else if (mem_wr_req && mem_wr_rdy) tb_issued <= 1'b1;
    else if (mem_wr_done) tb_issued <= 1'b0;
    assert (!(mem_wr_done && !tb_issued && !areset)) else $error("mem_wr_done without an issued write");
  end

  task automatic set_port(input int p, input logic [31:0] a, input logic [2:0] t);
    rq_rd_addr[32*p +: 32] = a;
    rq_rd_type[3*p +: 3] = t;
  endtask

  task automatic wait_rd(output int n);
    n = 0;
    forever begin
      @(negedge aclk);
      #1;
      if (mem_rd_req) break;
      n++;
      if (n > 20) begin
        n = -1;
        break;
      end
    end
  endtask

  task automatic accept_rd(output logic [NREQ-1:0] r);
    mem_rd_rdy = 1'b1;
    #1 r = rq_rd_rdy;
    @(negedge aclk);
    mem_rd_rdy = 1'b0;
    rq_rd_req = rq_rd_req & ~r;
  endtask

  task automatic beats(input int n, input bit fin, input logic [31:0] base);
    for (int b = 0; b < n; b++) begin
      if (b > 0) @(negedge aclk);
      mem_ret_valid = 1'b1;
      mem_ret_last = fin && b == n - 1;
      mem_ret_data = base + b;
      #1;
      vm[b] = rq_ret_valid;
      lm[b] = rq_ret_last;
      dm[b] = rq_ret_data;
    end
    @(negedge aclk);
    mem_ret_valid = 1'b0;
    mem_ret_last = 1'b0;
    mem_ret_data = '0;
    #1 idle_req = mem_rd_req;
  endtask

  task automatic test_reset();
    @(negedge aclk);
    @(negedge aclk);
    #1;
    total++;
    if ({mem_rd_req, mem_wr_req, rq_rd_rdy, rq_ret_valid, rq_ret_last} !== '0) $display("FAIL reset_ctl: got %b required 0", {mem_rd_req, mem_wr_req, rq_rd_rdy, rq_ret_valid, rq_ret_last});
    else passed++;
    total++;
    if (wr_rdy !== 1'b1) $display("FAIL reset_wr_rdy: got %b required 1", wr_rdy);
    else passed++;
    total++;
    if ({mem_rd_addr, mem_wr_addr, rq_ret_data} !== '0) $display("FAIL reset_addr: got %h required 0", {mem_rd_addr, mem_wr_addr, rq_ret_data});
    else passed++;
    areset = 1'b0;
  endtask

  task automatic test_grant_order();
    int n;
    logic [NREQ-1:0] r, oh;
    bit ok_v, ok_l, ok_d;
    set_port(ICACHE, 32'h100, RD_LINE);
    set_port(DCACHE, 32'h200, RD_LINE);
    set_port(UNCACHE, 32'h300, RD_LINE);
    rq_rd_req = 3'b111;
    for (int p = 0; p < 3; p++) begin
      oh = 3'b001 << p;
      wait_rd(n);
      total++;
      if (n !== 0 || mem_rd_addr !== 32'h100 * (p + 1) || mem_rd_type !== RD_LINE)
        $display("FAIL order_grant p%0d: wait %0d addr %h type %b required 0 %h %b", p, n, mem_rd_addr, mem_rd_type, 32'h100 * (p + 1), RD_LINE);
      else passed++;
      accept_rd(r);
      total++;
      if (r !== oh) $display("FAIL order_rdy p%0d: got %b required %b", p, r, oh);
      else passed++;
      beats(4, 1, 32'hA000 * (p + 1));
      ok_v = 1;
      ok_l = 1;
      ok_d = 1;
      for (int b = 0; b < 4; b++) begin
        if (vm[b] !== oh) ok_v = 0;
        if (lm[b] !== (b == 3 ? oh : 3'b000)) ok_l = 0;
        if (dm[b] !== 32'hA000 * (p + 1) + b) ok_d = 0;
      end
      total++;
      if (!ok_v) $display("FAIL order_valid p%0d: got %b %b %b %b required %b", p, vm[0], vm[1], vm[2], vm[3], oh);
      else passed++;
      total++;
      if (!ok_l) $display("FAIL order_last p%0d: got %b %b %b %b required last on beat 4 only", p, lm[0], lm[1], lm[2], lm[3]);
      else passed++;
      total++;
      if (!ok_d) $display("FAIL order_data p%0d: got %h %h %h %h required base+beat", p, dm[0], dm[1], dm[2], dm[3]);
      else passed++;
      total++;
      if (idle_req !== 1'b0) $display("FAIL order_idle p%0d: mem_rd_req %b required 0", p, idle_req);
      else passed++;
    end
  endtask

  task automatic test_round_robin();
    int n;
    logic [NREQ-1:0] r;
    set_port(DCACHE, 32'h400, RD_LINE);
    rq_rd_req = 3'b010;
    wait_rd(n);
    accept_rd(r);
    total++;
    if (n !== 0 || r !== 3'b010) $display("FAIL rr_first: wait %0d rdy %b required 0 010", n, r);
    else passed++;
    set_port(UNCACHE, 32'h500, RD_LINE);
    rq_rd_req = 3'b110;
    beats(4, 1, 32'h0);
    wait_rd(n);
    total++;
    if (n !== 0 || mem_rd_addr !== 32'h500) $display("FAIL rr_next: wait %0d addr %h required 0 00000500", n, mem_rd_addr);
    else passed++;
    accept_rd(r);
    total++;
    if (r !== 3'b100) $display("FAIL rr_rdy: got %b required 100", r);
    else passed++;
    beats(4, 1, 32'h0);
    wait_rd(n);
    accept_rd(r);
    total++;
    if (r !== 3'b010 || mem_rd_addr !== 32'h400) $display("FAIL rr_back: rdy %b addr %h required 010 00000400", r, mem_rd_addr);
    else passed++;
    beats(4, 1, 32'h0);
  endtask

  task automatic test_single_word();
    int n;
    logic [NREQ-1:0] r;
    set_port(UNCACHE, 32'hBFAF_8000, 3'b010);
    rq_rd_req = 3'b100;
    wait_rd(n);
    total++;
    if (n !== 0 || mem_rd_type !== 3'b010 || mem_rd_addr !== 32'hBFAF_8000) $display("FAIL single_req: wait %0d type %b addr %h required 0 010 bfaf8000", n, mem_rd_type, mem_rd_addr);
    else passed++;
    accept_rd(r);
    beats(1, 1, 32'h1234_5678);
    total++;
    if (vm[0] !== 3'b100 || lm[0] !== 3'b100 || dm[0] !== 32'h1234_5678) $display("FAIL single_beat: valid %b last %b data %h required 100 100 12345678", vm[0], lm[0], dm[0]);
    else passed++;
  endtask

  task automatic test_raw_hazard();
    int n, cnt;
    logic [NREQ-1:0] r;
    wr_req = 1'b1;
    wr_type = RD_LINE;
    wr_addr = 32'h1000;
    wr_wstrb = 4'h3;
    wr_data = {4{32'hCAFE_0001}};
    #1;
    total++;
    if (wr_rdy !== 1'b1) $display("FAIL raw_wr_rdy: got %b required 1", wr_rdy);
    else passed++;
    @(negedge aclk);
    wr_req = 1'b0;
    #1;
    total++;
    if (mem_wr_req !== 1'b1 || wr_rdy !== 1'b0 || mem_wr_addr !== 32'h1000 || mem_wr_wstrb !== 4'h3 || mem_wr_type !== RD_LINE)
      $display("FAIL raw_wr_issue: req %b rdy %b addr %h strb %h type %b required 1 0 00001000 3 100", mem_wr_req, wr_rdy, mem_wr_addr, mem_wr_wstrb, mem_wr_type);
    else passed++;
    mem_wr_rdy = 1'b1;
    @(negedge aclk);
    mem_wr_rdy = 1'b0;
    set_port(DCACHE, 32'h100C, 3'b010);
    rq_rd_req = 3'b010;
    cnt = 0;
    repeat (4) begin
      @(negedge aclk);
      #1;
      if (mem_rd_req) cnt++;
    end
    total++;
    if (cnt !== 0) $display("FAIL raw_block: mem_rd_req high %0d cycles required 0", cnt);
    else passed++;
    set_port(ICACHE, 32'h2000, 3'b010);
    rq_rd_req = 3'b011;
    wait_rd(n);
    total++;
    if (n !== 0 || mem_rd_addr !== 32'h2000) $display("FAIL raw_other: wait %0d addr %h required 0 00002000", n, mem_rd_addr);
    else passed++;
    accept_rd(r);
    beats(1, 1, 32'h0);
    total++;
    if (idle_req !== 1'b0) $display("FAIL raw_still_block: mem_rd_req %b required 0", idle_req);
    else passed++;
    mem_wr_done = 1'b1;
    @(negedge aclk);
    mem_wr_done = 1'b0;
    #1;
    total++;
    if (mem_rd_req !== 1'b0 || wr_rdy !== 1'b1) $display("FAIL raw_release_t1: rd_req %b wr_rdy %b required 0 1", mem_rd_req, wr_rdy);
    else passed++;
    @(negedge aclk);
    #1;
    total++;
    if (mem_rd_req !== 1'b1 || mem_rd_addr !== 32'h100C) $display("FAIL raw_release_t2: rd_req %b addr %h required 1 0000100c", mem_rd_req, mem_rd_addr);
    else passed++;
    accept_rd(r);
    beats(1, 1, 32'h0);
    total++;
    if (r !== 3'b010 || vm[0] !== 3'b010 || lm[0] !== 3'b010) $display("FAIL raw_serve: rdy %b valid %b last %b required 010", r, vm[0], lm[0]);
    else passed++;
  endtask

  task automatic test_write_backpressure();
    int p0;
    p0 = wr_pulses;
    wr_req = 1'b1;
    wr_addr = 32'h3000;
    wr_wstrb = 4'hF;
    wr_data = {4{32'hAAAA_5555}};
    @(negedge aclk);
    #1;
    total++;
    if (wr_rdy !== 1'b0) $display("FAIL wbp_busy: wr_rdy %b required 0", wr_rdy);
    else passed++;
    wr_addr = 32'h4000;
    wr_data = {4{32'h1357_9BDF}};
    mem_wr_rdy = 1'b1;
    @(negedge aclk);
    mem_wr_rdy = 1'b0;
    repeat (2) @(negedge aclk);
    #1;
    total++;
    if (wr_rdy !== 1'b0 || mem_wr_req !== 1'b0 || mem_wr_addr !== 32'h3000 || mem_wr_data !== {4{32'hAAAA_5555}})
      $display("FAIL wbp_hold: rdy %b req %b addr %h required 0 0 00003000", wr_rdy, mem_wr_req, mem_wr_addr);
    else passed++;
    mem_wr_done = 1'b1;
    @(negedge aclk);
    mem_wr_done = 1'b0;
    #1;
    total++;
    if (wr_rdy !== 1'b1 || mem_wr_req !== 1'b0) $display("FAIL wbp_free: rdy %b req %b required 1 0", wr_rdy, mem_wr_req);
    else passed++;
    @(negedge aclk);
    wr_req = 1'b0;
    #1;
    total++;
    if (mem_wr_req !== 1'b1 || wr_rdy !== 1'b0 || mem_wr_addr !== 32'h4000 || mem_wr_data !== {4{32'h1357_9BDF}})
      $display("FAIL wbp_second: req %b rdy %b addr %h required 1 0 00004000", mem_wr_req, wr_rdy, mem_wr_addr);
    else passed++;
    mem_wr_rdy = 1'b1;
    @(negedge aclk);
    mem_wr_rdy = 1'b0;
    @(negedge aclk);
    mem_wr_done = 1'b1;
    @(negedge aclk);
    mem_wr_done = 1'b0;
    #1;
    total++;
    if (wr_pulses - p0 !== 2 || wr_rdy !== 1'b1) $display("FAIL wbp_pulses: pulses %0d rdy %b required 2 1", wr_pulses - p0, wr_rdy);
    else passed++;
  endtask

  task automatic test_async_reset();
    int n;
    logic [NREQ-1:0] r;
    set_port(ICACHE, 32'h600, RD_LINE);
    rq_rd_req = 3'b001;
    wait_rd(n);
    accept_rd(r);
    beats(2, 0, 32'h0);
    mem_ret_valid = 1'b1;
    mem_ret_data = 32'hDEAD_BEEF;
    #1;
    total++;
    if (rq_ret_valid !== 3'b001 || rq_ret_data !== 32'hDEAD_BEEF) $display("FAIL ar_mid: valid %b data %h required 001 deadbeef", rq_ret_valid, rq_ret_data);
    else passed++;
    #1 areset = 1'b1;
    #1;
    total++;
    if ({rq_rd_rdy, rq_ret_valid, rq_ret_last, mem_rd_req, mem_wr_req} !== '0 || rq_ret_data !== '0 || mem_rd_addr !== '0 || mem_rd_type !== '0 || mem_wr_addr !== '0)
      $display("FAIL ar_async: ctl %b data %h addr %h required all 0", {rq_rd_rdy, rq_ret_valid, rq_ret_last, mem_rd_req, mem_wr_req}, rq_ret_data, mem_rd_addr);
    else passed++;
    @(negedge aclk);
    mem_ret_valid = 1'b0;
    mem_ret_data = '0;
    areset = 1'b0;
    set_port(ICACHE, 32'h700, RD_LINE);
    rq_rd_req = 3'b001;
    wait_rd(n);
    total++;
    if (n !== 0 || mem_rd_addr !== 32'h700) $display("FAIL ar_regrant: wait %0d addr %h required 0 00000700", n, mem_rd_addr);
    else passed++;
    accept_rd(r);
    beats(4, 1, 32'h0);
    total++;
    if (r !== 3'b001 || vm[3] !== 3'b001 || lm[3] !== 3'b001 || lm[2] !== 3'b000) $display("FAIL ar_serve: rdy %b valid %b last %b/%b required 001 001 001/000", r, vm[3], lm[3], lm[2]);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_grant_order();
    test_round_robin();
    test_single_word();
    test_raw_hazard();
    test_write_backpressure();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
